serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 14 +
 rtl/sipo.sv | 17 +
 rtl/serial_rx.sv | 104 ++++++++++
 tb/tb_serial_rx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default widths for the serial receiver
package serial_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SHIFT  = S_SHIFT,
    ST_PARITY = S_PARITY
  } state_t;
  localparam int DEF_BITS        = 8;
  localparam bit DEF_SHIFT_RIGHT = 1'b1;
  localparam bit DEF_PARITY_ODD  = 1'b0;
endpackage

// File: rtl/sipo.sv
// sipo: serial-in parallel-out shift register, direction chosen at elaboration
module sipo #(
  parameter int BITS        = 8,
  parameter bit SHIFT_RIGHT = 1'b1
) (
  input  logic            in_rst,
  input  logic            in_clk,
  input  logic            in_serial,
  input  logic            in_shift,
  output logic [BITS-1:0] out_parallel
);
  // new bits enter at the MSB when shifting right, at the LSB when shifting left
  always_ff @(posedge in_clk)
    if (in_rst) out_parallel <= '0;
    else if (in_shift) out_parallel <= SHIFT_RIGHT ? {in_serial, out_parallel[BITS-1:1]}
                                                   : {out_parallel[BITS-2:0], in_serial};
endmodule

// File: rtl/serial_rx.sv
// serial_rx: strobed serial receiver with ready/valid output and sticky errors; parity via SERIAL_RX_PARITY_EN
module serial_rx
  import serial_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter bit SHIFT_RIGHT = DEF_SHIFT_RIGHT,
  parameter bit PARITY_ODD  = DEF_PARITY_ODD
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial,
  input  logic            in_bit_en,
  input  logic            in_frame,
  input  logic            in_clr,
  input  logic            in_ready,
  output logic [BITS-1:0] out_parallel,
  output logic            out_valid,
  output logic            out_busy,
  output logic            out_overflow,
  output logic            out_frame_err,
  output logic            out_parity_err
);
  localparam int CW = $clog2(BITS) + 1;
  state_t        state;
  logic [CW-1:0] count;
  logic [BITS-1:0] word;
  logic done, strobe, last, shift, frame_drop, par_ok, ovf_set;
  assign strobe     = in_bit_en & in_frame;
  assign last       = count == CW'(BITS - 1);
  assign shift      = strobe && state != ST_PARITY;
  assign frame_drop = !in_frame && (count != '0 || state == ST_PARITY);
  assign out_busy   = count != '0 || state == ST_PARITY;
  assign ovf_set    = done && out_valid && !in_ready;
`ifdef SERIAL_RX_PARITY_EN
  assign par_ok = ((^word) ^ in_serial) == PARITY_ODD;
`else
  assign par_ok = 1'b1;
  logic unused_par;
  assign unused_par = PARITY_ODD;
`endif

  sipo #(.BITS(BITS), .SHIFT_RIGHT(SHIFT_RIGHT)) u_sipo (
    .in_rst       (in_rst),
    .in_clk       (in_clk),
    .in_serial    (in_serial),
    .in_shift     (shift),
    .out_parallel (word)
  );

  // bit counting and framing; done pulses for one cycle once a good word sits in the shifter
  always_ff @(posedge in_clk)
    if (in_rst) begin
      state <= ST_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (strobe) begin
          state <= ST_SHIFT;
          count <= CW'(1);
        end
      end else if (!in_frame) begin
        state <= ST_IDLE;
        count <= '0;
      end else if (state == ST_SHIFT && strobe) begin
        count <= last ? '0 : count + CW'(1);
`ifdef SERIAL_RX_PARITY_EN
        if (last) state <= ST_PARITY;
`else
        done <= last;
`endif
      end else if (state == ST_PARITY && strobe) begin
        state <= ST_SHIFT;
        done  <= par_ok;
      end
    end

  // output holding register: load on done unless an undelivered word would be lost
  always_ff @(posedge in_clk)
    if (in_rst) begin
      out_parallel <= '0;
      out_valid    <= 1'b0;
    end else if (done && !ovf_set) begin
      out_parallel <= word;
      out_valid    <= 1'b1;
    end else if (out_valid && in_ready) out_valid <= 1'b0;

  // sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge in_clk)
    if (in_rst) begin
      out_overflow   <= 1'b0;
      out_frame_err  <= 1'b0;
      out_parity_err <= 1'b0;
    end else begin
      out_overflow   <= ovf_set | (out_overflow & ~in_clr);
      out_frame_err  <= frame_drop | (out_frame_err & ~in_clr);
`ifdef SERIAL_RX_PARITY_EN
      out_parity_err <= (state == ST_PARITY && strobe && !par_ok) | (out_parity_err & ~in_clr);
`else
      out_parity_err <= 1'b0;
`endif
    end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed checks of serial_rx in both shift directions (parity cases when SERIAL_RX_PARITY_EN)
module tb_serial_rx;
  logic clk = 1'b0;
  logic rst, ser, ben, frame, clr, ready;
  logic [7:0] par_r, par_l;
  logic val_r, val_l, busy_r, busy_l, ovf_r, ovf_l, fe_r, fe_l, pe_r, pe_l;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_rx #(.BITS(8), .SHIFT_RIGHT(1'b1), .PARITY_ODD(1'b0)) dut_r (
    .in_clk(clk), .in_rst(rst), .in_serial(ser), .in_bit_en(ben), .in_frame(frame),
    .in_clr(clr), .in_ready(ready), .out_parallel(par_r), .out_valid(val_r),
    .out_busy(busy_r), .out_overflow(ovf_r), .out_frame_err(fe_r), .out_parity_err(pe_r));

  serial_rx #(.BITS(8), .SHIFT_RIGHT(1'b0), .PARITY_ODD(1'b0)) dut_l (
    .in_clk(clk), .in_rst(rst), .in_serial(ser), .in_bit_en(ben), .in_frame(frame),
    .in_clr(clr), .in_ready(ready), .out_parallel(par_l), .out_valid(val_l),
    .out_busy(busy_l), .out_overflow(ovf_l), .out_frame_err(fe_l), .out_parity_err(pe_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    ben = 1'b1;
    step();
    ben = 1'b0;
    step();
  endtask

  // sends w LSB-first (plus an even-parity bit, inverted when bad, in parity builds)
  task automatic send_word(input logic [7:0] w, input logic bad, input logic rdy_last, input logic v_before);
    logic [8:0] bits;
    int n;
    bits = {(^w) ^ bad, w};
`ifdef SERIAL_RX_PARITY_EN
    n = 9;
`else
    n = 8;
`endif
    for (int i = 0; i < n - 1; i++) send_bit(bits[i]);
    ser = bits[n-1];
    ben = 1'b1;
    step();
    ben = 1'b0;
    chk("latency_valid", {31'b0, val_r}, {31'b0, v_before});
    ready = rdy_last;
    step();
    ready = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [7:0] w);
    chk({tag, "_valid_r"}, {31'b0, val_r}, 32'd1);
    chk({tag, "_valid_l"}, {31'b0, val_l}, 32'd1);
    chk({tag, "_data_r"}, {24'b0, par_r}, {24'b0, w});
    chk({tag, "_data_l"}, {24'b0, par_l}, {24'b0, rev8(w)});
  endtask

  task automatic drain();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("drain_valid", {31'b0, val_r}, 32'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; ser = 1'b0; ben = 1'b0; frame = 1'b0; clr = 1'b0; ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {31'b0, val_r}, 32'd0);
    chk("rst_data", {24'b0, par_r}, 32'd0);
    chk("rst_busy", {31'b0, busy_r}, 32'd0);
    chk("rst_flags", {29'b0, ovf_r, fe_r, pe_r}, 32'd0);
    frame = 1'b1;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check_word("a5", 8'hA5);
    drain();
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    check_word("w11", 8'h11);
    send_word(8'h22, 1'b0, 1'b0, 1'b1);
    check_word("ovf_keep", 8'h11);
    chk("ovf_set", {31'b0, ovf_r}, 32'd1);
    pulse_clr();
    chk("ovf_clr", {31'b0, ovf_r}, 32'd0);
    send_word(8'h33, 1'b0, 1'b1, 1'b1);
    check_word("nobubble", 8'h33);
    chk("nobubble_ovf", {31'b0, ovf_r}, 32'd0);
    drain();
    w = 8'h96;
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    chk("mid_busy", {31'b0, busy_r}, 32'd1);
    frame = 1'b0;
    step();
    chk("drop_ferr", {31'b0, fe_r}, 32'd1);
    chk("drop_busy", {31'b0, busy_r}, 32'd0);
    chk("drop_valid", {31'b0, val_r}, 32'd0);
    frame = 1'b1;
    send_word(8'h96, 1'b0, 1'b0, 1'b0);
    check_word("after_drop", 8'h96);
    drain();
    pulse_clr();
    chk("ferr_clr", {31'b0, fe_r}, 32'd0);
`ifdef SERIAL_RX_PARITY_EN
    send_word(8'h03, 1'b1, 1'b0, 1'b0);
    chk("par_err", {31'b0, pe_r}, 32'd1);
    chk("par_bad_valid", {31'b0, val_r}, 32'd0);
    send_word(8'h03, 1'b0, 1'b0, 1'b0);
    check_word("par_ok", 8'h03);
    drain();
    pulse_clr();
    chk("perr_clr", {31'b0, pe_r}, 32'd0);
`else
    chk("no_parity_err", {31'b0, pe_r | pe_l}, 32'd0);
`endif
    send_word(8'h77, 1'b0, 1'b0, 1'b0);
    w = 8'h5A;
    for (int i = 0; i < 5; i++) send_bit(w[i]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", {30'b0, val_r, val_l}, 32'd0);
    chk("mrst_data", {16'b0, par_r, par_l}, 32'd0);
    chk("mrst_busy", {30'b0, busy_r, busy_l}, 32'd0);
    chk("mrst_flags", {29'b0, ovf_r, fe_r, pe_r}, 32'd0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    check_word("after_rst", 8'h5A);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
